// File: rtl/lsu_mem_master.sv
// Load/store initiator for a 4-byte-wide, byte-addressed RAM without byte enables.
// Sub-word stores are performed as read-modify-write; loads return extended data.
//
// state  | meaning
// IDLE   | ready for a request
// LD     | read issued, extended load data captured at the edge
// RMW_RD | read of the target word for a byte/half store, merge buffer captured
// ST_WR  | single write cycle (merged sub-word or full word)
// RESP   | response held until consumed
module lsu_mem_master #(
    parameter logic [31:0] RAM_ORI = 32'h0020_0000,
    parameter logic [31:0] RAM_LEN = 32'h0010_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        ram_wr_en_o,
    output logic [31:0] ram_wr_addr_o,
    output logic [31:0] ram_wr_data_o,
    output logic        ram_rd_en_o,
    output logic [31:0] ram_rd_addr_o,
    input  logic [31:0] ram_rd_data_i
);

    typedef enum logic [2:0] {
        S_IDLE, S_LD, S_RMW_RD, S_ST_WR, S_RESP
    } state_t;

    // Highest legal start address: the memory always touches 4 bytes.
    localparam logic [31:0] ADDR_LAST = RAM_ORI + RAM_LEN - 32'd4;

    state_t      r_state;
    state_t      w_next;
    logic        w_accept;
    logic        w_fault;
    logic [31:0] w_ld_ext;

    logic        r_we;
    logic        r_uns;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_merge;
    logic [31:0] r_rdata;
    logic        r_err;

    assign w_accept = req_valid_i && (r_state == S_IDLE);
    assign w_fault  = (req_size_i == 2'd3) || (req_addr_i < RAM_ORI) ||
                      (req_addr_i > ADDR_LAST);

    always_comb begin
        w_ld_ext = ram_rd_data_i;
        case (r_size)
            2'd0:    w_ld_ext = {{24{~r_uns & ram_rd_data_i[7]}}, ram_rd_data_i[7:0]};
            2'd1:    w_ld_ext = {{16{~r_uns & ram_rd_data_i[15]}}, ram_rd_data_i[15:0]};
            default: w_ld_ext = ram_rd_data_i;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_fault)                 w_next = S_RESP;
                    else if (!req_we_i)          w_next = S_LD;
                    else if (req_size_i == 2'd2) w_next = S_ST_WR;
                    else                         w_next = S_RMW_RD;
                end
            end
            S_LD:     w_next = S_RESP;
            S_RMW_RD: w_next = S_ST_WR;
            S_ST_WR:  w_next = S_RESP;
            S_RESP:   if (resp_ready_i) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_size  <= 2'd0;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_merge <= 32'h0;
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we    <= req_we_i;
                r_uns   <= req_unsigned_i;
                r_size  <= req_size_i;
                r_addr  <= req_addr_i;
                r_wdata <= req_wdata_i;
                r_rdata <= 32'h0;
                r_err   <= w_fault;
            end
            if (r_state == S_LD) begin
                r_rdata <= w_ld_ext;
            end
            if (r_state == S_RMW_RD) begin
                r_merge <= (r_size == 2'd0) ? {ram_rd_data_i[31:8], r_wdata[7:0]}
                                            : {ram_rd_data_i[31:16], r_wdata[15:0]};
            end
        end
    end

    // Outputs decode from the registered state only.
    always_comb begin
        req_ready_o   = 1'b0;
        resp_valid_o  = 1'b0;
        resp_rdata_o  = 32'h0;
        resp_err_o    = 1'b0;
        ram_wr_en_o   = 1'b0;
        ram_wr_addr_o = 32'h0;
        ram_wr_data_o = 32'h0;
        ram_rd_en_o   = 1'b0;
        ram_rd_addr_o = 32'h0;
        case (r_state)
            S_IDLE: req_ready_o = 1'b1;
            S_LD, S_RMW_RD: begin
                ram_rd_en_o   = 1'b1;
                ram_rd_addr_o = r_addr;
            end
            S_ST_WR: begin
                ram_wr_en_o   = 1'b1;
                ram_wr_addr_o = r_addr;
                ram_wr_data_o = (r_size == 2'd2) ? r_wdata : r_merge;
            end
            S_RESP: begin
                resp_valid_o = 1'b1;
                resp_rdata_o = r_we ? 32'h0 : r_rdata;
                resp_err_o   = r_err;
            end
            default: ;
        endcase
    end

    logic w_unused;
    assign w_unused = r_we & 1'b0;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: a byte-array RAM driven by the DUT, and a separate
// byte-array reference memory updated from the load/store rules directly.
module tb_lsu_mem_master;

    localparam logic [31:0] ORI = 32'h0020_0000;
    localparam int          LEN = 32'h0010_0000;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [1:0]  req_size_i = 2'd0;
    logic        req_unsigned_i = 1'b0;
    logic [31:0] req_addr_i = 32'h0;
    logic [31:0] req_wdata_i = 32'h0;
    logic        resp_valid_o;
    logic        resp_ready_i = 1'b0;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;
    logic        ram_wr_en_o;
    logic [31:0] ram_wr_addr_o;
    logic [31:0] ram_wr_data_o;
    logic        ram_rd_en_o;
    logic [31:0] ram_rd_addr_o;
    logic [31:0] ram_rd_data_i = 32'h0;

    int n_vec = 0;
    int n_mis = 0;
    int oob_wr = 0;

    logic [7:0] mem     [LEN];
    logic [7:0] ref_mem [LEN];

    lsu_mem_master #(.RAM_ORI(ORI), .RAM_LEN(LEN)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_size_i(req_size_i),
        .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
        .ram_wr_en_o(ram_wr_en_o), .ram_wr_addr_o(ram_wr_addr_o),
        .ram_wr_data_o(ram_wr_data_o),
        .ram_rd_en_o(ram_rd_en_o), .ram_rd_addr_o(ram_rd_addr_o),
        .ram_rd_data_i(ram_rd_data_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic bit in_range(input logic [31:0] a);
        return (longint'(a) >= longint'(ORI)) && (longint'(a) <= longint'(ORI) + LEN - 4);
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        int i;
        if (!in_range(a)) return 32'h0;
        i = int'(a - ORI);
        return {mem[i+3], mem[i+2], mem[i+1], mem[i]};
    endfunction

    // Memory read data is settled well before the next rising edge.
    always @(negedge clk_i)
        ram_rd_data_i = ram_rd_en_o ? mem_word(ram_rd_addr_o) : 32'h0;

    always @(posedge clk_i) begin
        if (ram_wr_en_o) begin
            if (!in_range(ram_wr_addr_o)) oob_wr++;
            else begin
                for (int k = 0; k < 4; k++)
                    mem[int'(ram_wr_addr_o - ORI) + k] = ram_wr_data_o[8*k +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] size,
                                               input logic uns);
        longint v = 0;
        int n = nbytes(size);
        int base = int'(a - ORI);
        for (int k = 0; k < n; k++) v += longint'(ref_mem[base + k]) << (8 * k);
        if (n < 4 && !uns && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic check_idle(input string tag);
        check({tag, ":idle_out"},
              {req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, ram_wr_en_o,
               ram_wr_addr_o, ram_wr_data_o, ram_rd_en_o, ram_rd_addr_o},
              {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0});
    endtask

    // Issues one request from #1 after a rising edge and returns the response data.
    task automatic run_req(input string tag, input logic we, input logic [1:0] size,
                           input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                           input int hold, output logic [31:0] got);
        bit f;
        int exp_lat, lat, nrd, nwr, exp_nrd, exp_nwr, bad;
        logic [31:0] exp_rd;
        f       = (size == 2'd3) || !in_range(addr);
        exp_rd  = (f || we) ? 32'h0 : model_load(addr, size, uns);
        exp_lat = f ? 1 : (we && size != 2'd2) ? 3 : 2;
        exp_nrd = (!f && (!we || size != 2'd2)) ? 1 : 0;
        exp_nwr = (!f && we) ? 1 : 0;
        req_we_i = we; req_size_i = size; req_unsigned_i = uns;
        req_addr_i = addr; req_wdata_i = wdata; req_valid_i = 1'b1;
        check({tag, ":req_ready"}, req_ready_o, 1'b1);
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        lat = 0; nrd = 0; nwr = 0; bad = 0;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            if (ram_rd_en_o) begin nrd++; if (ram_rd_addr_o !== addr) bad++; end
            if (ram_wr_en_o) begin nwr++; if (ram_wr_addr_o !== addr) bad++; end
            if (ram_rd_en_o && ram_wr_en_o) bad++;
            if (req_ready_o) bad++;
            if (resp_valid_o) lat = c;
            else begin @(posedge clk_i); #1; end
        end
        got = resp_rdata_o;
        check({tag, ":latency"}, lat, exp_lat);
        check({tag, ":rdata"}, resp_rdata_o, exp_rd);
        check({tag, ":err"}, resp_err_o, f);
        check({tag, ":rd_count"}, nrd, exp_nrd);
        check({tag, ":wr_count"}, nwr, exp_nwr);
        check({tag, ":protocol"}, bad, 0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk_i); #1;
            check({tag, ":hold"}, {resp_valid_o, req_ready_o, resp_rdata_o, resp_err_o},
                  {1'b1, 1'b0, got, f});
        end
        resp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        resp_ready_i = 1'b0;
        check({tag, ":back_idle"}, {resp_valid_o, req_ready_o}, 2'b01);
        if (!f && we)
            for (int k = 0; k < nbytes(size); k++)
                ref_mem[int'(addr - ORI) + k] = wdata[8*k +: 8];
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] edges [6];
        logic [31:0] a;
        logic [1:0]  sz;

        for (int i = 0; i < LEN; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        for (int k = 0; k < 4; k++) begin
            mem[16 + k] = 8'(32'h8899AABB >> (8 * k));
            ref_mem[16 + k] = mem[16 + k];
        end

        #12;
        check_idle("in_reset");
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        check_idle("after_reset");

        run_req("lb_s", 1'b0, 2'd0, 1'b0, 32'h0020_0010, 32'h0, 0, got);
        check("tp_lb_s", got, 32'hFFFF_FFBB);
        run_req("lb_u", 1'b0, 2'd0, 1'b1, 32'h0020_0010, 32'h0, 0, got);
        check("tp_lb_u", got, 32'h0000_00BB);
        run_req("lh_mis", 1'b0, 2'd1, 1'b0, 32'h0020_0011, 32'h0, 0, got);
        check("tp_lh_mis", got, 32'hFFFF_99AA);
        run_req("lw", 1'b0, 2'd2, 1'b1, 32'h0020_0010, 32'h0, 0, got);
        check("tp_lw", got, 32'h8899_AABB);
        run_req("sb", 1'b1, 2'd0, 1'b0, 32'h0020_0012, 32'h0000_0055, 0, got);
        run_req("lw_after_sb", 1'b0, 2'd2, 1'b0, 32'h0020_0010, 32'h0, 0, got);
        check("tp_merge", got, 32'h8855_AABB);

        run_req("f_size3", 1'b0, 2'd3, 1'b0, 32'h0020_0010, 32'h0, 0, got);
        run_req("f_low", 1'b0, 2'd2, 1'b0, 32'h001F_FFFF, 32'h0, 0, got);
        run_req("f_high", 1'b1, 2'd0, 1'b0, 32'h002F_FFFD, 32'h12, 0, got);
        run_req("edge_ok", 1'b0, 2'd2, 1'b0, 32'h002F_FFFC, 32'h0, 0, got);

        run_req("sw_hold", 1'b1, 2'd2, 1'b0, 32'h0020_0020, 32'hDEAD_BEEF, 3, got);
        run_req("lw_sw", 1'b0, 2'd2, 1'b0, 32'h0020_0020, 32'h0, 0, got);
        check("tp_sw", got, 32'hDEAD_BEEF);

        // Reset during the read half of a read-modify-write.
        req_we_i = 1'b1; req_size_i = 2'd0; req_unsigned_i = 1'b0;
        req_addr_i = 32'h0020_0012; req_wdata_i = 32'h77; req_valid_i = 1'b1;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        check("rst_in_rmw_rd", ram_rd_en_o, 1'b1);
        rst_i = 1'b0;
        #1;
        check_idle("rst_async");
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        check_idle("rst_release");
        run_req("lw_after_rst", 1'b0, 2'd2, 1'b0, 32'h0020_0010, 32'h0, 0, got);
        check("tp_no_write", got, 32'h8855_AABB);

        edges[0] = ORI - 32'd1;
        edges[1] = ORI + LEN - 32'd3;
        edges[2] = ORI + LEN - 32'd4;
        edges[3] = ORI + LEN - 32'd6;
        edges[4] = 32'h0;
        edges[5] = 32'hFFFF_FFFF;
        for (int n = 0; n < 80; n++) begin
            a  = ($urandom_range(0, 7) == 0) ? edges[$urandom_range(0, 5)]
                                             : ORI + 32'($urandom_range(0, 47));
            sz = ($urandom_range(0, 11) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            run_req("rand", 1'($urandom), sz, 1'($urandom), a, $urandom,
                    int'($urandom_range(0, 2)), got);
        end

        for (int off = 0; off < 48; off += 4)
            run_req("final_scan", 1'b0, 2'd2, 1'b0, ORI + 32'(off), 32'h0, 0, got);
        check("oob_writes", oob_wr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
